ab_seq_gen: RTL

AB_SEQ_GEN -- requirements
Module: ab_seq_gen

---
 rtl/ab_seq_gen.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ab_seq_gen.sv
// ---------------------------------------------------------------------------
// ab_seq_gen -- A/B symbol sequence generator for exercising a pattern
// detector.
//
// A small pattern memory holds up to DEPTH two-bit symbols {A,B}. A start
// request replays the first len entries as a registered A/B stream with
// valid high. The pass is repeated rep extra times. Consecutive passes are
// separated by a one-cycle gap in which A = B = valid = 0, so the detector
// under test sees a clean break. After the last pass, done pulses for one
// cycle.
//
// Optional feature (compile-time macro AB_SEQ_GEN_HIT_CNT_EN):
//   When defined, hit_count counts the cycles where valid & y_in during the
//   most recent transmission. It clears on an accepted start and saturates
//   at all-ones.
//   When undefined, hit_count is tied to zero and y_in is ignored.
//
// Ports
//   clk          rising-edge clock for all state
//   async_reset  asynchronous, active-high reset
//   wr_en        pattern write strobe (honoured only while idle)
//   wr_addr      pattern entry index
//   wr_data      symbol {A,B}; bit 1 = A, bit 0 = B
//   len          symbols per pass (0..DEPTH), captured on accepted start
//   rep          extra passes (total = rep+1), captured on accepted start
//   start        request one transmission (honoured only while idle)
//   abort        synchronous cancel; also blocks a same-cycle start
//   y_in         detector match flag
//   A, B         registered symbol stream
//   valid        A/B carry a pattern symbol this cycle
//   busy         transmission in progress (SEND or GAP)
//   done         one-cycle completion pulse
//   hit_count    detector hits seen during the last transmission
// ---------------------------------------------------------------------------
module ab_seq_gen #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       async_reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [1:0]                 wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic [3:0]                 rep,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       y_in,
  output logic                       A,
  output logic                       B,
  output logic                       valid,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           hit_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [AW-1:0] IDX_ONE = AW'(1'b1);
  localparam logic [AW:0]   LEN_ONE = (AW + 1)'(1'b1);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] idx_nxt_s;
  logic [3:0]    pass_r;
  logic [3:0]    pass_nxt_s;
  logic [AW:0]   len_r;
  logic [AW:0]   len_nxt_s;
  logic [3:0]    rep_r;
  logic [3:0]    rep_nxt_s;
  logic          start_acc_s;
  logic          last_sym_s;
  logic          mem_we_s;
  logic [1:0]    rd_data_s;
  logic          a_r;
  logic          b_r;
  logic          valid_r;
  logic          busy_r;
  logic          done_r;

  logic [1:0]    mem_r [DEPTH];

  // The pattern memory is writable only while idle, so a running pass
  // always sees a stable pattern.
  assign mem_we_s = wr_en && (state_r == ST_IDLE);

  // This is the final symbol of the current pass. len_r is nonzero whenever
  // the FSM is in SEND.
  assign last_sym_s = ({1'b0, idx_r} == (len_r - LEN_ONE));

  // Next-state, counter and configuration-capture logic.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    pass_nxt_s  = pass_r;
    len_nxt_s   = len_r;
    rep_nxt_s   = rep_r;
    start_acc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          start_acc_s = 1'b1;
          len_nxt_s   = len;
          rep_nxt_s   = rep;
          idx_nxt_s   = '0;
          pass_nxt_s  = '0;
          if (len != '0) begin
            state_nxt_s = ST_SEND;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = '0;
          pass_nxt_s  = '0;
        end else if (last_sym_s) begin
          idx_nxt_s = '0;
          if (pass_r != rep_r) begin
            state_nxt_s = ST_GAP;
            pass_nxt_s  = pass_r + 4'd1;
          end else begin
            state_nxt_s = ST_DONE;
            pass_nxt_s  = '0;
          end
        end else begin
          idx_nxt_s = idx_r + IDX_ONE;
        end
      end
      ST_GAP: begin
        idx_nxt_s = '0;
        if (abort) begin
          state_nxt_s = ST_IDLE;
          pass_nxt_s  = '0;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = '0;
        pass_nxt_s  = '0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = '0;
        pass_nxt_s  = '0;
      end
    endcase
  end

  // Read the symbol for the next cycle. A same-cycle write to that entry is
  // forwarded, so a start issued together with a write sends the new value.
  always_comb begin
    if (mem_we_s && (wr_addr == idx_nxt_s)) begin
      rd_data_s = wr_data;
    end else begin
      rd_data_s = mem_r[idx_nxt_s];
    end
  end

  // Pattern memory storage. It has no reset, so its contents persist across
  // async_reset and are undefined after power-up.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // FSM state, counters and registered outputs. The outputs are derived
  // from the next state, so they line up with the state they describe.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      pass_r  <= '0;
      len_r   <= '0;
      rep_r   <= '0;
      a_r     <= 1'b0;
      b_r     <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      pass_r  <= pass_nxt_s;
      len_r   <= len_nxt_s;
      rep_r   <= rep_nxt_s;
      valid_r <= (state_nxt_s == ST_SEND);
      busy_r  <= (state_nxt_s == ST_SEND) || (state_nxt_s == ST_GAP);
      done_r  <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_SEND) begin
        a_r <= rd_data_s[1];
        b_r <= rd_data_s[0];
      end else begin
        a_r <= 1'b0;
        b_r <= 1'b0;
      end
    end
  end

  assign A     = a_r;
  assign B     = b_r;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;

`ifdef AB_SEQ_GEN_HIT_CNT_EN
  localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HIT_ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] hit_r;

  // Saturating hit counter. It clears on an accepted start and holds its
  // value through abort.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      hit_r <= '0;
    end else if (start_acc_s) begin
      hit_r <= '0;
    end else if (valid_r && y_in && (hit_r != HIT_MAX)) begin
      hit_r <= hit_r + HIT_ONE;
    end
  end

  assign hit_count = hit_r;
`else
  // Hit counting is compiled out. The match flag is deliberately ignored.
  logic unused_y_in_s;
  logic unused_start_acc_s;

  assign unused_y_in_s      = y_in;
  assign unused_start_acc_s = start_acc_s;
  assign hit_count          = {CNT_W{1'b0}};
`endif

endmodule
